// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg
// Shared types and sizing helpers for the 1:16 TDM receiver.
// Items:
//   tdm_state_t   receiver state (HUNT while searching for frame_sync, LOCKED once aligned)
//   slot_w()      slot counter width for a given frame size and parity option
//   DEF_NSLOTS    default slots per frame
//   PARITY_EN     1 when TDM_DEMUX_PARITY_EN is defined (an extra parity slot ends each frame)
//   DEF_SLOT_W    slot counter width for the default build
package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int DEF_NSLOTS = 16;

  // The parity slot sits at index NSLOTS, so it needs one more counter bit.
  function automatic int slot_w(input int nslots, input bit parity);
    slot_w = $clog2(nslots) + (parity ? 1 : 0);
  endfunction

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int DEF_SLOT_W = slot_w(DEF_NSLOTS, PARITY_EN);

endpackage

// File: rtl/tdm_demux16_if.sv
// tdm_demux16_if
// Bundles the serial input side and the parallel result side of the TDM receiver.
// Signals:
//   din, din_valid, frame_sync   serial beat from the link (driven by master)
//   y                            last complete frame
//   frame_done, sync_err,
//   parity_err                   single-cycle status pulses
//   slot                         slot index expected on the next valid beat
// Modports: master (link source / bench), slave (receiver).
interface tdm_demux16_if
  import tdm_demux_pkg::*;
#(
  parameter int NSLOTS = DEF_NSLOTS,
  parameter int SLOT_W = DEF_SLOT_W
);
  logic              din;
  logic              din_valid;
  logic              frame_sync;
  logic [NSLOTS-1:0] y;
  logic              frame_done;
  logic              sync_err;
  logic [SLOT_W-1:0] slot;
  logic              parity_err;

  modport master (
    output din, din_valid, frame_sync,
    input  y, frame_done, sync_err, slot, parity_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y, frame_done, sync_err, slot, parity_err
  );
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter
// Slot counter for the TDM receiver: load-to-1, increment, explicit wrap to 0.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load1      start of a new frame (the current beat was slot 0)
//   inc        accept one beat; wraps to 0 after LAST instead of overflowing
//   count      current slot index
//   is_last    count is at the last slot of the frame
module tdm_slot_counter #(
  parameter int W    = 4,
  parameter int LAST = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         is_last
);

  assign is_last = (count == W'(LAST));

  // load1 wins over inc: a resync beat always restarts the frame at slot 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load1) begin
      count <= W'(1);
    end else if (inc) begin
      count <= is_last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16
// 1:16 time-division demultiplexer: collects one bit per valid beat into a shadow
// register and publishes the full frame to y when the frame completes.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   tdm_demux16_if.slave (din/din_valid/frame_sync in; y, frame_done,
//         sync_err, slot, parity_err out)
// Option macro TDM_DEMUX_PARITY_EN: adds an even-parity slot after the data slots;
// a frame with bad parity raises parity_err and leaves y unchanged.
module tdm_demux16
  import tdm_demux_pkg::*;
#(
  parameter int NSLOTS = DEF_NSLOTS,
  parameter int SLOT_W = slot_w(NSLOTS, PARITY_EN)
) (
  input logic          clk,
  input logic          rst,
  tdm_demux16_if.slave bus
);

  localparam int IDX_W     = $clog2(NSLOTS);
  localparam int LAST_SLOT = PARITY_EN ? NSLOTS : NSLOTS - 1;

  tdm_state_t        state, state_nxt;
  logic [NSLOTS-1:0] shadow;
  logic [NSLOTS-1:0] pub_data;
  logic [SLOT_W-1:0] slot_q;
  logic [IDX_W-1:0]  wr_idx;
  logic              is_last;
  logic              is_zero;
  logic              load1;
  logic              inc;
  logic              wr_bit;
  logic              publish;
  logic              sync_err_nxt;
  logic              frame_done_q;
  logic              sync_err_q;
  logic [NSLOTS-1:0] y_q;

  tdm_slot_counter #(
    .W    (SLOT_W),
    .LAST (LAST_SLOT)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load1   (load1),
    .inc     (inc),
    .count   (slot_q),
    .is_last (is_last)
  );

  assign is_zero = (slot_q == '0);
  // A resync beat is always slot 0, whatever the counter currently says.
  assign wr_idx  = load1 ? '0 : slot_q[IDX_W-1:0];

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_fail;
  logic parity_err_q;
  logic parity_ok;

  assign parity_ok = ~(^{shadow, bus.din});

  always_comb begin
    pub_data = shadow;
  end
`else
  // The last data bit is taken straight from din so y updates on the same edge.
  always_comb begin
    pub_data         = shadow;
    pub_data[wr_idx] = bus.din;
  end
`endif

  // Next-state and beat decode; nothing happens on cycles without din_valid.
  always_comb begin
    state_nxt    = state;
    load1        = 1'b0;
    inc          = 1'b0;
    wr_bit       = 1'b0;
    publish      = 1'b0;
    sync_err_nxt = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_fail  = 1'b0;
`endif
    if (bus.din_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            load1     = 1'b1;
            wr_bit    = 1'b1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync && !is_zero) begin
            sync_err_nxt = 1'b1;
            load1        = 1'b1;
            wr_bit       = 1'b1;
          end else if (is_zero && !bus.frame_sync) begin
            sync_err_nxt = 1'b1;
            state_nxt    = HUNT;
          end else begin
            inc = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            if (is_last) begin
              publish     = parity_ok;
              parity_fail = ~parity_ok;
            end else begin
              wr_bit = 1'b1;
            end
`else
            wr_bit  = 1'b1;
            publish = is_last;
`endif
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // State, shadow, output frame and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      shadow       <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= publish;
      sync_err_q   <= sync_err_nxt;
      if (wr_bit) begin
        shadow[wr_idx] <= bus.din;
      end
      if (publish) begin
        y_q <= pub_data;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity failure pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_fail;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.y          = y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16
// Directed bench for tdm_demux16 with hand-computed expected frames.
// Define TDM_DEMUX_PARITY_EN to also exercise the parity slot.
module tb_tdm_demux16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;
  int   serr_cnt;
  int   perr_cnt;

  tdm_demux16_if bus ();

  tdm_demux16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of stimulus; outputs are sampled 1 unit after the rising edge.
  task automatic drive_beat(input logic v, input logic fs, input logic d);
    bus.din_valid  = v;
    bus.frame_sync = fs;
    bus.din        = d;
    @(posedge clk);
    #1;
    if (bus.frame_done) done_cnt++;
    if (bus.sync_err) serr_cnt++;
    if (bus.parity_err) perr_cnt++;
  endtask

  // Full frame, LSB first, sync on slot 0, correct parity when enabled.
  task automatic send_frame(input logic [15:0] d);
    for (int i = 0; i < 16; i++) drive_beat(1'b1, i == 0, d[i]);
`ifdef TDM_DEMUX_PARITY_EN
    drive_beat(1'b1, 1'b0, ^d);
`endif
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    serr_cnt = 0;
    perr_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b0);
    drive_beat(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    checks++; if (bus.y !== 16'h0000) begin failures++; $display("[TB] FAIL reset_y: got %h expected %h", bus.y, 16'h0000); end
    checks++; if (bus.slot !== '0) begin failures++; $display("[TB] FAIL reset_slot: got %0d expected 0", bus.slot); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_sync_err: got %b expected 0", bus.sync_err); end
    checks++; if (bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity_err: got %b expected 0", bus.parity_err); end
  endtask

  task automatic test_single_frame();
    logic [15:0] d;
    d = 16'hA5C3;
    clear_counts();
    drive_beat(1'b1, 1'b1, d[0]);
    checks++; if (bus.slot !== 1) begin failures++; $display("[TB] FAIL single_slot1: got %0d expected 1", bus.slot); end
    for (int i = 1; i < 16; i++) drive_beat(1'b1, 1'b0, d[i]);
`ifdef TDM_DEMUX_PARITY_EN
    drive_beat(1'b1, 1'b0, ^d);
`endif
    checks++; if (bus.y !== 16'hA5C3) begin failures++; $display("[TB] FAIL single_y: got %h expected %h", bus.y, 16'hA5C3); end
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("[TB] FAIL single_done: got %b expected 1", bus.frame_done); end
    checks++; if (bus.slot !== 0) begin failures++; $display("[TB] FAIL single_slot_wrap: got %0d expected 0", bus.slot); end
    drive_beat(1'b0, 1'b0, 1'b0);
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_pulse: got %b expected 0", bus.frame_done); end
    checks++; if (bus.y !== 16'hA5C3) begin failures++; $display("[TB] FAIL single_y_hold: got %h expected %h", bus.y, 16'hA5C3); end
    checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(16'h0001);
    checks++; if (bus.y !== 16'h0001) begin failures++; $display("[TB] FAIL b2b_y0: got %h expected %h", bus.y, 16'h0001); end
    send_frame(16'h8000);
    checks++; if (bus.y !== 16'h8000) begin failures++; $display("[TB] FAIL b2b_y1: got %h expected %h", bus.y, 16'h8000); end
    checks++; if (done_cnt !== 2) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (serr_cnt + perr_cnt !== 0) begin failures++; $display("[TB] FAIL b2b_errors: got %0d expected 0", serr_cnt + perr_cnt); end
  endtask

  task automatic test_hunt();
    rst = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 5; i++) drive_beat(1'b1, 1'b0, 1'b1);
    checks++; if (bus.y !== 16'h0000) begin failures++; $display("[TB] FAIL hunt_y: got %h expected %h", bus.y, 16'h0000); end
    checks++; if (bus.slot !== 0) begin failures++; $display("[TB] FAIL hunt_slot: got %0d expected 0", bus.slot); end
    checks++; if (done_cnt + serr_cnt + perr_cnt !== 0) begin failures++; $display("[TB] FAIL hunt_pulses: got %0d expected 0", done_cnt + serr_cnt + perr_cnt); end
    send_frame(16'hFFFF);
    checks++; if (bus.y !== 16'hFFFF) begin failures++; $display("[TB] FAIL hunt_lock_y: got %h expected %h", bus.y, 16'hFFFF); end
  endtask

  task automatic test_sync_errors();
    logic [15:0] d;
    d = 16'h1234;
    for (int i = 0; i < 7; i++) drive_beat(1'b1, i == 0, 1'b1);
    checks++; if (bus.slot !== 7) begin failures++; $display("[TB] FAIL sync_slot7: got %0d expected 7", bus.slot); end
    clear_counts();
    drive_beat(1'b1, 1'b1, d[0]);
    checks++; if (bus.sync_err !== 1'b1) begin failures++; $display("[TB] FAIL resync_err: got %b expected 1", bus.sync_err); end
    checks++; if (bus.slot !== 1) begin failures++; $display("[TB] FAIL resync_slot: got %0d expected 1", bus.slot); end
    for (int i = 1; i < 16; i++) drive_beat(1'b1, 1'b0, d[i]);
`ifdef TDM_DEMUX_PARITY_EN
    drive_beat(1'b1, 1'b0, ^d);
`endif
    checks++; if (bus.y !== 16'h1234) begin failures++; $display("[TB] FAIL resync_y: got %h expected %h", bus.y, 16'h1234); end
    checks++; if (done_cnt !== 1 || serr_cnt !== 1) begin failures++; $display("[TB] FAIL resync_counts: got done=%0d serr=%0d expected done=1 serr=1", done_cnt, serr_cnt); end
    drive_beat(1'b1, 1'b0, 1'b1);
    checks++; if (bus.sync_err !== 1'b1) begin failures++; $display("[TB] FAIL missing_sync_err: got %b expected 1", bus.sync_err); end
    checks++; if (bus.slot !== 0) begin failures++; $display("[TB] FAIL missing_sync_slot: got %0d expected 0", bus.slot); end
    drive_beat(1'b1, 1'b0, 1'b1);
    checks++; if (bus.sync_err !== 1'b0) begin failures++; $display("[TB] FAIL hunt_after_loss: got %b expected 0", bus.sync_err); end
    checks++; if (bus.y !== 16'h1234) begin failures++; $display("[TB] FAIL loss_y_hold: got %h expected %h", bus.y, 16'h1234); end
  endtask

  task automatic test_gaps_reset();
    logic [15:0] d;
    d = 16'h6C39;
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        for (int g = 0; g < 3; g++) drive_beat(1'b0, 1'b1, ~d[i]);
        checks++; if (bus.slot !== 5) begin failures++; $display("[TB] FAIL gap_slot_hold: got %0d expected 5", bus.slot); end
      end
      if (i == 12) drive_beat(1'b0, 1'b1, ~d[i]);
      drive_beat(1'b1, i == 0, d[i]);
    end
`ifdef TDM_DEMUX_PARITY_EN
    drive_beat(1'b0, 1'b1, ~(^d));
    drive_beat(1'b1, 1'b0, ^d);
`endif
    checks++; if (bus.y !== 16'h6C39) begin failures++; $display("[TB] FAIL gap_y: got %h expected %h", bus.y, 16'h6C39); end
    checks++; if (done_cnt !== 1 || serr_cnt !== 0) begin failures++; $display("[TB] FAIL gap_counts: got done=%0d serr=%0d expected done=1 serr=0", done_cnt, serr_cnt); end
    for (int i = 0; i < 9; i++) drive_beat(1'b1, i == 0, 1'b1);
    checks++; if (bus.slot !== 9) begin failures++; $display("[TB] FAIL pre_reset_slot: got %0d expected 9", bus.slot); end
    rst = 1'b1;
    drive_beat(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    checks++; if (bus.y !== 16'h0000) begin failures++; $display("[TB] FAIL midframe_reset_y: got %h expected %h", bus.y, 16'h0000); end
    checks++; if (bus.slot !== 0) begin failures++; $display("[TB] FAIL midframe_reset_slot: got %0d expected 0", bus.slot); end
    drive_beat(1'b1, 1'b0, 1'b1);
    checks++; if (bus.sync_err !== 1'b0 || bus.slot !== 0) begin failures++; $display("[TB] FAIL reset_to_hunt: got sync_err=%b slot=%0d expected sync_err=0 slot=0", bus.sync_err, bus.slot); end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    rst = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    clear_counts();
    send_frame(16'h0003);
    checks++; if (bus.y !== 16'h0003) begin failures++; $display("[TB] FAIL parity_good_y: got %h expected %h", bus.y, 16'h0003); end
    checks++; if (bus.frame_done !== 1'b1 || bus.parity_err !== 1'b0) begin failures++; $display("[TB] FAIL parity_good_flags: got done=%b perr=%b expected done=1 perr=0", bus.frame_done, bus.parity_err); end
    send_frame(16'h0000);
    for (int i = 0; i < 16; i++) drive_beat(1'b1, i == 0, i < 2);
    drive_beat(1'b1, 1'b0, 1'b1);
    checks++; if (bus.parity_err !== 1'b1 || bus.frame_done !== 1'b0) begin failures++; $display("[TB] FAIL parity_bad_flags: got done=%b perr=%b expected done=0 perr=1", bus.frame_done, bus.parity_err); end
    checks++; if (bus.y !== 16'h0000) begin failures++; $display("[TB] FAIL parity_bad_y_hold: got %h expected %h", bus.y, 16'h0000); end
    checks++; if (bus.slot !== 0) begin failures++; $display("[TB] FAIL parity_bad_slot: got %0d expected 0", bus.slot); end
  endtask
`endif

  // Test sequence.
  initial begin
    checks         = 0;
    failures       = 0;
    done_cnt       = 0;
    serr_cnt       = 0;
    perr_cnt       = 0;
    rst            = 1'b1;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hunt();
    test_sync_errors();
    test_gaps_reset();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
